// File: rtl/line_draw_pkg.sv
// Shared state encoding and default geometry for the Bresenham line engine.
package line_draw_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StStep  = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam int unsigned X_LIMIT_DEF   = 320;
    localparam int unsigned Y_LIMIT_DEF   = 240;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0800_0000;

endpackage

// File: rtl/line_draw_engine_setup.sv
// Normalisation stage: folds steep lines onto the x axis and orders endpoints.
// Line constants are registered here; the start cursor is handed to the parent on the same edge.
module line_setup #(
    parameter int unsigned CW = 9,
    parameter int unsigned W  = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic [CW-1:0]       x0_i,
    input  logic [CW-1:0]       y0_i,
    input  logic [CW-1:0]       x1_i,
    input  logic [CW-1:0]       y1_i,
    output logic [CW-1:0]       x_start_o,
    output logic [CW-1:0]       y_start_o,
    output logic signed [W-1:0] err_init_o,
    output logic                steep_o,
    output logic                ystep_neg_o,
    output logic [CW-1:0]       x_end_o,
    output logic [W-1:0]        dx_o,
    output logic [W-1:0]        dy_o
);
    logic [CW-1:0] adx, ady, ax0, ay0, ax1, ay1, sy1, ddx, ddy;
    logic          steep, swap, neg;
    logic          steep_q, steep_d, ystep_neg_q, ystep_neg_d;
    logic [CW-1:0] x_end_q, x_end_d;
    logic [W-1:0]  dx_q, dx_d, dy_q, dy_d;

    always_comb begin
        adx   = (x1_i >= x0_i) ? x1_i - x0_i : x0_i - x1_i;
        ady   = (y1_i >= y0_i) ? y1_i - y0_i : y0_i - y1_i;
        steep = ady > adx;
        ax0   = steep ? y0_i : x0_i;
        ay0   = steep ? x0_i : y0_i;
        ax1   = steep ? y1_i : x1_i;
        ay1   = steep ? x1_i : y1_i;
        swap  = ax0 > ax1;
        x_start_o = swap ? ax1 : ax0;
        y_start_o = swap ? ay1 : ay0;
        x_end_d   = swap ? ax0 : ax1;
        sy1       = swap ? ay0 : ay1;
        ddx  = x_end_d - x_start_o;
        neg  = sy1 < y_start_o;
        ddy  = neg ? y_start_o - sy1 : sy1 - y_start_o;
        err_init_o  = W'(0) - W'(ddx >> 1);
        steep_d     = steep;
        ystep_neg_d = neg;
        dx_d        = W'(ddx);
        dy_d        = W'(ddy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            steep_q     <= 1'b0;
            ystep_neg_q <= 1'b0;
            x_end_q     <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
        end else if (en_i) begin
            steep_q     <= steep_d;
            ystep_neg_q <= ystep_neg_d;
            x_end_q     <= x_end_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
        end
    end

    assign steep_o     = steep_q;
    assign ystep_neg_o = ystep_neg_q;
    assign x_end_o     = x_end_q;
    assign dx_o        = dx_q;
    assign dy_o        = dy_q;

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line engine: Go/Done endpoint intake, per-pixel Draw/Write_Finish requests,
// with screen clipping, a rotating 16-bit dash mask, abort and a written-pixel counter.
module line_draw_engine import line_draw_pkg::*; #(
    parameter int unsigned X_W         = 9,
    parameter int unsigned Y_W         = 8,
    parameter int unsigned X_LIMIT     = X_LIMIT_DEF,
    parameter int unsigned Y_LIMIT     = Y_LIMIT_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
    parameter int unsigned ROW_SHIFT   = 9,
    parameter int unsigned PIXEL_SHIFT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           Go,
    input  logic [X_W-1:0] X0,
    input  logic [X_W-1:0] X1,
    input  logic [Y_W-1:0] Y0,
    input  logic [Y_W-1:0] Y1,
    input  logic [15:0]    Pattern,
    input  logic           Abort,
    output logic           Done,
    output logic           Draw,
    output logic [31:0]    Pixel_Address,
    input  logic           Write_Finish,
    output logic [15:0]    Pixel_Count
);
    localparam int unsigned CW = (X_W > Y_W) ? X_W : Y_W;
    localparam int unsigned W  = CW + 2;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [CW-1:0]        x_q, x_d, y_q, y_d;
    logic signed [W-1:0]  err_q, err_d;
    logic [15:0]          pattern_q, pattern_d, count_q, count_d;
    logic                 abort_q, abort_d;
    logic [31:0]          addr_q, addr_d;

    logic [CW-1:0]        x_start, y_start, x_end, px, py;
    logic signed [W-1:0]  err_init, dx, dy, err_sum;
    logic [W-1:0]         dx_u, dy_u;
    logic                 steep, ystep_neg, in_bounds, visible, last;
    logic [31:0]          plot_addr;

    line_setup #(.CW(CW), .W(W)) u_setup (
        .clk         (clk),
        .reset       (reset),
        .en_i        (state_q == StSetup),
        .x0_i        (x0_q),
        .y0_i        (y0_q),
        .x1_i        (x1_q),
        .y1_i        (y1_q),
        .x_start_o   (x_start),
        .y_start_o   (y_start),
        .err_init_o  (err_init),
        .steep_o     (steep),
        .ystep_neg_o (ystep_neg),
        .x_end_o     (x_end),
        .dx_o        (dx_u),
        .dy_o        (dy_u)
    );

    always_comb begin
        dx        = dx_u;
        dy        = dy_u;
        px        = steep ? y_q : x_q;
        py        = steep ? x_q : y_q;
        in_bounds = (32'(px) < X_LIMIT) && (32'(py) < Y_LIMIT);
        visible   = in_bounds && pattern_q[0];
        last      = (x_q == x_end);
        plot_addr = BASE_ADDR + (((32'(py) << ROW_SHIFT) | 32'(px)) << PIXEL_SHIFT);
        err_sum   = err_q + dy;

        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        x_d       = x_q;
        y_d       = y_q;
        err_d     = err_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        abort_d   = abort_q;
        addr_d    = addr_q;

        unique case (state_q)
            StIdle: begin
                if (Go) begin
                    x0_d      = CW'(X0);
                    y0_d      = CW'(Y0);
                    x1_d      = CW'(X1);
                    y1_d      = CW'(Y1);
                    pattern_d = Pattern;
                    count_d   = '0;
                    abort_d   = 1'b0;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                x_d     = x_start;
                y_d     = y_start;
                err_d   = err_init;
                state_d = Abort ? StDone : StStep;
            end
            StStep: begin
                if (Abort) begin
                    state_d = StDone;
                end else if (visible) begin
                    addr_d  = plot_addr;
                    state_d = StWait;
                end else if (last) begin
                    state_d = StDone;
                end
            end
            StWait: begin
                if (Abort) abort_d = 1'b1;
                if (Write_Finish) begin
                    count_d = count_q + 16'd1;
                    state_d = (abort_q || Abort || last) ? StDone : StStep;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A pixel is consumed (clipped, masked or written) whenever the cursor moves on.
        if ((state_q == StStep && !Abort && !visible && !last) ||
            (state_q == StWait && Write_Finish && state_d == StStep)) begin
            x_d       = x_q + CW'(1);
            pattern_d = {pattern_q[0], pattern_q[15:1]};
            if (err_sum > 0) begin
                y_d   = ystep_neg ? y_q - CW'(1) : y_q + CW'(1);
                err_d = err_sum - dx;
            end else begin
                err_d = err_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            err_q     <= '0;
            pattern_q <= '0;
            count_q   <= '0;
            abort_q   <= 1'b0;
            addr_q    <= BASE_ADDR;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x_q       <= x_d;
            y_q       <= y_d;
            err_q     <= err_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            abort_q   <= abort_d;
            addr_q    <= addr_d;
        end
    end

    assign Done          = (state_q == StIdle);
    assign Draw          = (state_q == StWait);
    assign Pixel_Address = addr_q;
    assign Pixel_Count   = count_q;

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed bench for line_draw_engine: address sequences, counts, latency, clip, abort, reset.
module tb_line_draw_engine;
    localparam logic [31:0] BASE = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Go = 1'b0;
    logic [8:0]  X0 = '0, X1 = '0;
    logic [7:0]  Y0 = '0, Y1 = '0;
    logic [15:0] Pattern = '0;
    logic        Abort = 1'b0;
    logic        Done, Draw;
    logic [31:0] Pixel_Address;
    logic        Write_Finish = 1'b0;
    logic [15:0] Pixel_Count;

    int total = 0;
    int bad = 0;

    logic [31:0] addrs [8];
    int n_draw, first_draw, done_cyc, draw_cycles, unstable;

    always #5 clk = ~clk;

    line_draw_engine dut (
        .clk           (clk),
        .reset         (reset),
        .Go            (Go),
        .X0            (X0),
        .X1            (X1),
        .Y0            (Y0),
        .Y1            (Y1),
        .Pattern       (Pattern),
        .Abort         (Abort),
        .Done          (Done),
        .Draw          (Draw),
        .Pixel_Address (Pixel_Address),
        .Write_Finish  (Write_Finish),
        .Pixel_Count   (Pixel_Count)
    );

    // Issues one line and services each write after wf_delay cycles of Draw; cycles are
    // counted in falling edges after the Go edge. abort_at pulses Abort in the first WAIT.
    task automatic run_line(input logic [8:0] x0, input logic [7:0] y0, input logic [8:0] x1,
                            input logic [7:0] y1, input logic [15:0] pat, input int wf_delay,
                            input int abort_at);
        int wait_cnt;
        n_draw = 0; first_draw = -1; done_cyc = -1; draw_cycles = 0; unstable = 0;
        wait_cnt = 0;
        @(negedge clk);
        X0 = x0; Y0 = y0; X1 = x1; Y1 = y1; Pattern = pat; Go = 1'b1;
        @(negedge clk);
        Go = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            Write_Finish = 1'b0;
            Abort = 1'b0;
            if (Done) begin
                done_cyc = cyc;
                break;
            end
            if (Draw) begin
                draw_cycles++;
                if (wait_cnt == 0) begin
                    if (n_draw < 8) addrs[n_draw] = Pixel_Address;
                    if (first_draw < 0) first_draw = cyc;
                end else if (n_draw < 8 && Pixel_Address !== addrs[n_draw]) begin
                    unstable++;
                end
                if (n_draw == 0 && wait_cnt == abort_at) Abort = 1'b1;
                if (wait_cnt == wf_delay) begin
                    Write_Finish = 1'b1;
                    n_draw++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (Done !== 1'b1) begin bad++; $display("FAIL reset_done got %b want 1", Done); end
        total++; if (Draw !== 1'b0) begin bad++; $display("FAIL reset_draw got %b want 0", Draw); end
        total++; if (Pixel_Address !== BASE) begin
            bad++; $display("FAIL reset_addr got %h want %h", Pixel_Address, BASE);
        end
        total++; if (Pixel_Count !== 16'd0) begin
            bad++; $display("FAIL reset_count got %0d want 0", Pixel_Count);
        end
        reset = 1'b0;
    endtask

    task automatic test_horizontal();
        logic [31:0] exp_a [4];
        exp_a = '{BASE, BASE + 32'h2, BASE + 32'h4, BASE + 32'h6};
        run_line(9'd0, 8'd0, 9'd3, 8'd0, 16'hFFFF, 1, -1);
        for (int i = 0; i < 4; i++) begin
            total++; if (addrs[i] !== exp_a[i]) begin
                bad++; $display("FAIL horiz_addr%0d got %h want %h", i, addrs[i], exp_a[i]);
            end
        end
        total++; if (Pixel_Count !== 16'd4) begin
            bad++; $display("FAIL horiz_count got %0d want 4", Pixel_Count);
        end
        total++; if (first_draw != 3) begin
            bad++; $display("FAIL horiz_first_draw got %0d want 3", first_draw);
        end
        total++; if (done_cyc != 15) begin
            bad++; $display("FAIL horiz_done_cycle got %0d want 15", done_cyc);
        end
        total++; if (unstable != 0) begin
            bad++; $display("FAIL horiz_addr_stable got %0d want 0", unstable);
        end
    endtask

    task automatic test_reverse_diag();
        logic [31:0] exp_a [4];
        exp_a = '{BASE, BASE + 32'h402, BASE + 32'h804, BASE + 32'hC06};
        run_line(9'd3, 8'd3, 9'd0, 8'd0, 16'hFFFF, 0, -1);
        for (int i = 0; i < 4; i++) begin
            total++; if (addrs[i] !== exp_a[i]) begin
                bad++; $display("FAIL diag_addr%0d got %h want %h", i, addrs[i], exp_a[i]);
            end
        end
        total++; if (Pixel_Count !== 16'd4) begin
            bad++; $display("FAIL diag_count got %0d want 4", Pixel_Count);
        end
        total++; if (done_cyc != 11) begin
            bad++; $display("FAIL diag_done_cycle got %0d want 11", done_cyc);
        end
    endtask

    task automatic test_steep();
        logic [31:0] exp_a [4];
        exp_a = '{BASE + 32'h00A, BASE + 32'h40A, BASE + 32'h80C, BASE + 32'hC0C};
        run_line(9'd5, 8'd0, 9'd6, 8'd3, 16'hFFFF, 0, -1);
        for (int i = 0; i < 4; i++) begin
            total++; if (addrs[i] !== exp_a[i]) begin
                bad++; $display("FAIL steep_addr%0d got %h want %h", i, addrs[i], exp_a[i]);
            end
        end
        total++; if (Pixel_Count !== 16'd4) begin
            bad++; $display("FAIL steep_count got %0d want 4", Pixel_Count);
        end
    endtask

    task automatic test_clip_pattern();
        run_line(9'd316, 8'd0, 9'd323, 8'd0, 16'h5555, 0, -1);
        total++; if (n_draw != 2) begin
            bad++; $display("FAIL clip_draws got %0d want 2", n_draw);
        end
        total++; if (addrs[0] !== BASE + 32'h278) begin
            bad++; $display("FAIL clip_addr0 got %h want %h", addrs[0], BASE + 32'h278);
        end
        total++; if (addrs[1] !== BASE + 32'h27C) begin
            bad++; $display("FAIL clip_addr1 got %h want %h", addrs[1], BASE + 32'h27C);
        end
        total++; if (Pixel_Count !== 16'd2) begin
            bad++; $display("FAIL clip_count got %0d want 2", Pixel_Count);
        end
        // 1 setup + 8 step + 2 wait + 1 done + 1 return to idle
        total++; if (done_cyc != 13) begin
            bad++; $display("FAIL clip_done_cycle got %0d want 13", done_cyc);
        end
    endtask

    task automatic test_abort_wait();
        run_line(9'd0, 8'd0, 9'd3, 8'd0, 16'hFFFF, 10, 2);
        total++; if (n_draw != 1) begin
            bad++; $display("FAIL abort_draws got %0d want 1", n_draw);
        end
        total++; if (draw_cycles != 11) begin
            bad++; $display("FAIL abort_draw_cycles got %0d want 11", draw_cycles);
        end
        total++; if (addrs[0] !== BASE) begin
            bad++; $display("FAIL abort_addr got %h want %h", addrs[0], BASE);
        end
        total++; if (Pixel_Count !== 16'd1) begin
            bad++; $display("FAIL abort_count got %0d want 1", Pixel_Count);
        end
        total++; if (done_cyc != 15) begin
            bad++; $display("FAIL abort_done_cycle got %0d want 15", done_cyc);
        end
    endtask

    task automatic test_idle_hold();
        @(negedge clk);
        Abort = 1'b1; Write_Finish = 1'b1;
        repeat (2) @(negedge clk);
        Abort = 1'b0; Write_Finish = 1'b0;
        @(negedge clk);
        total++; if (Pixel_Count !== 16'd1) begin
            bad++; $display("FAIL idle_count_hold got %0d want 1", Pixel_Count);
        end
        total++; if (Done !== 1'b1) begin bad++; $display("FAIL idle_done got %b want 1", Done); end
        total++; if (Draw !== 1'b0) begin bad++; $display("FAIL idle_draw got %b want 0", Draw); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        X0 = 9'd0; Y0 = 8'd0; X1 = 9'd3; Y1 = 8'd0; Pattern = 16'hFFFF; Go = 1'b1;
        @(negedge clk);
        Go = 1'b0;
        for (int i = 0; i < 20 && !Draw; i++) @(negedge clk);
        total++; if (Draw !== 1'b1) begin
            bad++; $display("FAIL rst_wait_reached got %b want 1", Draw);
        end
        reset = 1'b1;
        @(negedge clk);
        total++; if (Draw !== 1'b0) begin bad++; $display("FAIL rst_wait_draw got %b want 0", Draw); end
        total++; if (Done !== 1'b1) begin bad++; $display("FAIL rst_wait_done got %b want 1", Done); end
        total++; if (Pixel_Count !== 16'd0) begin
            bad++; $display("FAIL rst_wait_count got %0d want 0", Pixel_Count);
        end
        reset = 1'b0;
        run_line(9'd0, 8'd1, 9'd1, 8'd1, 16'hFFFF, 0, -1);
        total++; if (addrs[0] !== BASE + 32'h400) begin
            bad++; $display("FAIL after_rst_addr0 got %h want %h", addrs[0], BASE + 32'h400);
        end
        total++; if (addrs[1] !== BASE + 32'h402) begin
            bad++; $display("FAIL after_rst_addr1 got %h want %h", addrs[1], BASE + 32'h402);
        end
        total++; if (Pixel_Count !== 16'd2) begin
            bad++; $display("FAIL after_rst_count got %0d want 2", Pixel_Count);
        end
        total++; if (done_cyc != 7) begin
            bad++; $display("FAIL after_rst_done_cycle got %0d want 7", done_cyc);
        end
    endtask

    task automatic test_zero_length();
        run_line(9'd7, 8'd2, 9'd7, 8'd2, 16'hFFFF, 0, -1);
        total++; if (n_draw != 1 || addrs[0] !== BASE + 32'h80E) begin
            bad++; $display("FAIL zero_len got n=%0d addr=%h want n=1 addr=%h",
                            n_draw, addrs[0], BASE + 32'h80E);
        end
        total++; if (Pixel_Count !== 16'd1) begin
            bad++; $display("FAIL zero_len_count got %0d want 1", Pixel_Count);
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_reverse_diag();
        test_steep();
        test_clip_pattern();
        test_abort_wait();
        test_idle_hold();
        test_reset_in_wait();
        test_zero_length();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
